// File: rtl/conv2d_stream_pkg.sv
// conv2d_stream_pkg
// Shared definitions for the streaming convolution engine:
//   - product and accumulator width helpers
//   - tap index encoding (t = r*K + c, bias at BIAS_TAP = K*K)
//   - pipeline control word carried alongside the datapath
package conv2d_stream_pkg;

    // Valid bit plus end-of-frame flag, travels with each pipeline stage.
    typedef struct packed {
        logic vld;
        logic eof;
    } pipe_ctrl_t;

    // Zero-extended pixel times signed weight.
    function automatic int prod_w(input int data_w, input int weight_w);
        return data_w + weight_w + 1;
    endfunction

    // Wide enough that summing K*K products cannot overflow.
    function automatic int acc_w(input int data_w, input int weight_w, input int k);
        return prod_w(data_w, weight_w) + $clog2(k * k);
    endfunction

    // Row 0 is the oldest line, column 0 the oldest pixel of the window.
    function automatic int tap_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

    // The slot after the last kernel tap holds the channel bias.
    function automatic int bias_tap(input int k);
        return k * k;
    endfunction

endpackage

// File: rtl/conv_line_delay.sv
// conv_line_delay
// One-line delay of accepted pixels: data_o is the pixel that was written
// exactly DEPTH enables ago. Gaps in en_i do not disturb the delay.
// Ports:
//   clk, rst_n : clock, async active-low reset (pointer only)
//   en_i       : advance the line by one pixel
//   data_i     : pixel entering the line
//   data_o     : pixel leaving the line (valid in the cycle en_i is high)
module conv_line_delay #(
    parameter int DEPTH  = 200,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are never cleared; stale data is masked by window-valid logic.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

    // Read-before-write on the same slot gives exactly DEPTH of delay.
    assign data_o = mem_q[ptr_q];

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream
// Streaming KxK convolution over unsigned pixels, OUT_CH channels in parallel.
// Pipeline: window reg -> product reg -> sum+bias reg -> output reg
// (shift, ReLU, saturate). Output appears 3 edges after the accepting edge.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   in_data/in_valid   : pixel stream, no backpressure
//   in_sof             : marks the accepted pixel as (0,0)
//   w_we/w_ch/w_tap    : weight/bias write (tap K*K is the bias)
//   w_data             : signed weight or bias value
//   out_valid/out_data : one result per channel, channel c at [c*OUT_W +: OUT_W]
//   out_eof            : last output of the frame
module conv2d_stream
    import conv2d_stream_pkg::*;
#(
    parameter int IMG_W    = 200,
    parameter int IMG_H    = 200,
    parameter int K        = 5,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 16,
    parameter int OUT_CH   = 4,
    parameter int SHIFT    = 8,
    parameter int OUT_W    = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [DATA_W-1:0]                            in_data,
    input  logic                                         in_valid,
    input  logic                                         in_sof,
    input  logic                                         w_we,
    input  logic [((OUT_CH > 1) ? $clog2(OUT_CH) : 1)-1:0] w_ch,
    input  logic [$clog2(K*K+1)-1:0]                     w_tap,
    input  logic signed [WEIGHT_W-1:0]                   w_data,
    output logic                                         out_valid,
    output logic [OUT_CH*OUT_W-1:0]                      out_data,
    output logic                                         out_eof
);

    localparam int NT     = K * K;
    localparam int BT     = bias_tap(K);
    localparam int PROD_W = prod_w(DATA_W, WEIGHT_W);
    localparam int ACC_W  = acc_w(DATA_W, WEIGHT_W, K);
    localparam int CH_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int TAP_W  = $clog2(K * K + 1);
    localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    function automatic logic signed [PROD_W-1:0] mul_px(
        input logic        [DATA_W-1:0]   px,
        input logic signed [WEIGHT_W-1:0] w
    );
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = $signed({{(WEIGHT_W + 1){1'b0}}, px});
        b = {{(DATA_W + 1){w[WEIGHT_W-1]}}, w};
        return a * b;
    endfunction

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    logic [XW-1:0] x_q, x_d, pos_x;
    logic [YW-1:0] y_q, y_d, pos_y;
    logic          win_ok;
    logic          eof_px;

    always_comb begin
        // sof overrides whatever the counters believed
        pos_x = in_sof ? '0 : x_q;
        pos_y = in_sof ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (in_valid) begin
            if (pos_x == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (pos_y == YW'(IMG_H - 1)) ? '0 : pos_y + YW'(1);
            end else begin
                x_d = pos_x + XW'(1);
                y_d = pos_y;
            end
        end
        win_ok = in_valid && (pos_x >= XW'(K - 1)) && (pos_y >= YW'(K - 1));
        eof_px = (pos_x == XW'(IMG_W - 1)) && (pos_y == YW'(IMG_H - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // ------------------------------------------------------------------
    // Line storage and window
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ld_in  [K-1];
    logic [DATA_W-1:0] ld_out [K-1];
    logic [DATA_W-1:0] col    [K];
    logic [DATA_W-1:0] win_q  [K][K];

    assign ld_in[0] = in_data;

    for (genvar j = 0; j < K - 1; j++) begin : g_line
        if (j > 0) begin : g_chain
            assign ld_in[j] = ld_out[j-1];
        end
        conv_line_delay #(
            .DEPTH  (IMG_W),
            .DATA_W (DATA_W)
        ) u_line (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (in_valid),
            .data_i (ld_in[j]),
            .data_o (ld_out[j])
        );
    end

    // Row K-1 is the live pixel; each further line delay is one row older.
    always_comb begin
        col[K-1] = in_data;
        for (int r = 0; r < K - 1; r++) begin
            col[r] = ld_out[K-2-r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (in_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K-1] <= col[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Weight and bias registers
    // ------------------------------------------------------------------
    logic signed [WEIGHT_W-1:0] wgt_q [OUT_CH][NT+1];
    logic                       w_hit;

    assign w_hit = w_we
                && (w_tap <= TAP_W'(BT))
                && ({1'b0, w_ch} < (CH_W + 1)'(OUT_CH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < OUT_CH; ch++) begin
                for (int t = 0; t <= NT; t++) begin
                    wgt_q[ch][t] <= '0;
                end
            end
        end else if (w_hit) begin
            wgt_q[w_ch][w_tap] <= w_data;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    pipe_ctrl_t s1_q, s2_q, s3_q, s4_q;
    pipe_ctrl_t s1_d;

    always_comb begin
        s1_d.vld = win_ok;
        s1_d.eof = win_ok && eof_px;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            s4_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s1_q;
            s3_q <= s2_q;
            s4_q <= s3_q;
        end
    end

    assign out_valid = s4_q.vld;
    assign out_eof   = s4_q.eof;

    // ------------------------------------------------------------------
    // Per-channel MAC, adder tree and output stage
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < OUT_CH; ch++) begin : g_ch
        logic signed [PROD_W-1:0]   prod_q [NT];
        logic signed [WEIGHT_W-1:0] bias_q;
        logic signed [ACC_W-1:0]    acc_d, acc_q, sh;
        logic [OUT_W-1:0]           res_d, res_q;

        // Bias is captured with the products so a live write affects
        // products and bias of the same window consistently.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int t = 0; t < NT; t++) begin
                    prod_q[t] <= '0;
                end
                bias_q <= '0;
                acc_q  <= '0;
                res_q  <= '0;
            end else begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        prod_q[tap_idx(r, c, K)] <= mul_px(win_q[r][c], wgt_q[ch][tap_idx(r, c, K)]);
                    end
                end
                bias_q <= wgt_q[ch][BT];
                acc_q  <= acc_d;
                if (s3_q.vld) begin
                    res_q <= res_d;
                end
            end
        end

        always_comb begin
            acc_d = $signed({{(ACC_W - WEIGHT_W){bias_q[WEIGHT_W-1]}}, bias_q});
            for (int t = 0; t < NT; t++) begin
                acc_d = acc_d + $signed({{(ACC_W - PROD_W){prod_q[t][PROD_W-1]}}, prod_q[t]});
            end
        end

        always_comb begin
            sh    = acc_q >>> SHIFT;
            res_d = sh[OUT_W-1:0];
            if (sh[ACC_W-1]) begin
                res_d = '0;
            end else if (sh > OUT_MAX) begin
                res_d = '1;
            end
        end

        assign out_data[ch*OUT_W +: OUT_W] = res_q;
    end

endmodule
